// File: rtl/core_switch.sv
// core_switch: inter-core mailbox switch.
// One single-entry mailbox per ordered (source, destination) core pair.
// Port p sends into row p (mb[p][*]) and receives from column p (mb[*][p]),
// so no arbitration is ever needed.
//
// Ports (p = 0..SWITCH_CORE_SIZE-1):
//   clock, reset          rising-edge clock, async active-high reset
//   send_ready[p]         core p offers a message
//   send_core_idx[p]      destination core of that message
//   send_data[p]          payload, SWITCH_WIDTH shortreal words (raw bits)
//   send_ok[p]            one-cycle acceptance pulse
//   recv_request[p]       core p wants a message
//   recv_core_idx[p]      source core it wants to receive from
//   recv_ready[p]         one-cycle delivery pulse
//   recv_data[p]          delivered payload, held until the next delivery
//   idle                  all mailboxes empty and no pulse output high
module core_switch #(
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                          send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]  send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                          send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                          recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                          recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]  recv_data,
  output logic                                                 idle
);
  localparam int N = SWITCH_CORE_SIZE;
  localparam int W = SWITCH_WIDTH;
  localparam int A = SWITCH_CORE_ADDR_SIZE;

  typedef logic [W-1:0][31:0] payload_t;

  logic [N-1:0][N-1:0] full_q, full_d;   // [src][dst]
  payload_t            mb_q [N][N];      // [src][dst]
  logic [N-1:0]        send_hold_q, recv_hold_q;
  logic [N-1:0]        acc, dlv;
  logic [N-1:0][W-1:0][31:0] recv_data_q, recv_data_d;
  logic                idle_q, idle_d;

  // Accept/deliver decisions use pre-edge state only. An accept needs an
  // empty mailbox and a delivery needs a full one, so the two can never hit
  // the same mailbox on the same edge: a full mailbox is drained first and
  // the blocked writer simply retries.
  for (genvar p = 0; p < N; p++) begin : g_lane
    assign acc[p] = send_ready[p]   & ~send_hold_q[p] & ~full_q[p][send_core_idx[p]];
    assign dlv[p] = recv_request[p] & ~recv_hold_q[p] &  full_q[recv_core_idx[p]][p];
  end

  always_comb begin
    full_d = full_q;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (dlv[d] && recv_core_idx[d] == A'(s)) full_d[s][d] = 1'b0;
        if (acc[s] && send_core_idx[s] == A'(d)) full_d[s][d] = 1'b1;
      end
    end
  end

  always_comb begin
    recv_data_d = recv_data_q;
    for (int p = 0; p < N; p++) begin
      if (dlv[p]) recv_data_d[p] = mb_q[recv_core_idx[p]][p];
    end
  end

  // acc/dlv become next cycle's pulses, so they count as "not idle".
  assign idle_d = ~|full_d & ~|acc & ~|dlv;

  // The hold flags double as the pulse outputs: set on the serviced edge,
  // cleared on the next, which masks the still-held request during the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q      <= '0;
      send_hold_q <= '0;
      recv_hold_q <= '0;
      recv_data_q <= '0;
      idle_q      <= 1'b1;
    end else begin
      full_q      <= full_d;
      send_hold_q <= acc;
      recv_hold_q <= dlv;
      recv_data_q <= recv_data_d;
      idle_q      <= idle_d;
    end
  end

  // Payload storage is qualified by the full flags, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int s = 0; s < N; s++) begin
      if (acc[s]) mb_q[s][send_core_idx[s]] <= send_data[s];
    end
  end

  assign send_ok    = send_hold_q;
  assign recv_ready = recv_hold_q;
  assign recv_data  = recv_data_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_core_switch.sv
module tb_core_switch;
  localparam int N = 4;
  localparam int W = 16;
  localparam int A = 2;
  localparam int PW = W * 32;

  logic                       clock, reset;
  logic [N-1:0]               send_ready, send_ok, recv_request, recv_ready;
  logic [N-1:0][A-1:0]        send_core_idx, recv_core_idx;
  logic [N-1:0][W-1:0][31:0]  send_data, recv_data;
  logic                       idle;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one FIFO per ordered pair, index src*N+dst.
  logic [PW-1:0] q [N*N][$];

  core_switch #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) dut (
    .clock(clock), .reset(reset),
    .send_ready(send_ready), .send_core_idx(send_core_idx), .send_data(send_data),
    .send_ok(send_ok),
    .recv_request(recv_request), .recv_core_idx(recv_core_idx),
    .recv_ready(recv_ready), .recv_data(recv_data), .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // IEEE-754 single bits of a small positive integer.
  function automatic logic [31:0] fbits(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7fffff)};
  endfunction

  function automatic logic [PW-1:0] rndp();
    logic [PW-1:0] v;
    for (int i = 0; i < W; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [PW-1:0] pay, pa, pb, pc, pd, h0, h1, h2;
    logic [PW-1:0] sd [N];
    int acks, hits, k, src, s_tmo[N], r_tmo[N];
    bit mid;

    reset = 1'b0;
    send_ready = '0; send_core_idx = '0; send_data = '0;
    recv_request = '0; recv_core_idx = '0;

    // ---- reset, asserted between edges ----
    #2 reset = 1'b1;
    #1;
    chk("rst_send_ok", send_ok, 0);
    chk("rst_recv_ready", recv_ready, 0);
    chk("rst_idle", idle, 1);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_recv_data", recv_data, 0);
    chk("rst_idle_after", idle, 1);

    // ---- basic transfer 0 -> 2 ----
    for (int i = 0; i < W; i++) pay[i*32 +: 32] = fbits(i + 1);
    send_ready[0] = 1; send_core_idx[0] = 2; send_data[0] = pay;
    tick();
    chk("basic_send_ok", send_ok, 4'b0001);
    chk("basic_not_idle", idle, 0);
    send_ready[0] = 0;
    tick();
    chk("basic_ok_pulse_end", send_ok, 0);
    recv_request[2] = 1; recv_core_idx[2] = 0;
    tick();
    chk("basic_recv_ready", recv_ready, 4'b0100);
    chk("basic_recv_data", recv_data[2], pay);
    recv_request[2] = 0;
    tick();
    chk("basic_recv_pulse_end", recv_ready, 0);
    chk("basic_idle", idle, 1);
    chk("basic_data_held", recv_data[2], pay);

    // ---- back-pressure 1 -> 3 ----
    pa = rndp(); pb = rndp();
    send_ready[1] = 1; send_core_idx[1] = 3; send_data[1] = pa;
    tick();
    chk("bp_ack_a", send_ok, 4'b0010);
    send_data[1] = pb;
    acks = 0;
    repeat (20) begin tick(); if (send_ok[1]) acks++; end
    chk("bp_no_ack_b", acks, 0);
    recv_request[3] = 1; recv_core_idx[3] = 1;
    tick();
    chk("bp_recv_a", recv_ready, 4'b1000);
    chk("bp_data_a", recv_data[3], pa);
    chk("bp_b_blocked", send_ok, 0);
    tick();
    chk("bp_ack_b", send_ok, 4'b0010);
    chk("bp_no_dup_recv", recv_ready, 0);
    send_ready[1] = 0;
    tick();
    chk("bp_recv_b", recv_ready, 4'b1000);
    chk("bp_data_b", recv_data[3], pb);
    recv_request[3] = 0;
    tick();
    chk("bp_idle", idle, 1);

    // ---- all cores at once, ring ----
    for (int p = 0; p < N; p++) begin
      sd[p] = rndp();
      send_ready[p] = 1; send_core_idx[p] = A'((p + 1) % N); send_data[p] = sd[p];
    end
    tick();
    chk("ring_send_ok", send_ok, 4'b1111);
    send_ready = '0;
    for (int p = 0; p < N; p++) begin
      recv_request[p] = 1; recv_core_idx[p] = A'((p + N - 1) % N);
    end
    tick();
    chk("ring_recv_ready", recv_ready, 4'b1111);
    for (int p = 0; p < N; p++)
      chk($sformatf("ring_data%0d", p), recv_data[p], sd[(p + N - 1) % N]);
    recv_request = '0;
    tick();
    chk("ring_idle", idle, 1);

    // ---- hold flags mask the pulse cycle even if the index changes ----
    h0 = rndp(); h1 = rndp(); h2 = rndp();
    send_ready[0] = 1; send_core_idx[0] = 3; send_data[0] = h0;
    send_ready[1] = 1; send_core_idx[1] = 3; send_data[1] = h1;
    tick();
    chk("hold_send_ok", send_ok, 4'b0011);
    send_core_idx[0] = 2; send_data[0] = h2;
    send_ready[1] = 0;
    recv_request[3] = 1; recv_core_idx[3] = 0;
    tick();
    chk("hold_send_masked", send_ok, 0);
    chk("hold_recv_latency", recv_ready, 4'b1000);
    chk("hold_data0", recv_data[3], h0);
    recv_core_idx[3] = 1;
    tick();
    chk("hold_send_next", send_ok, 4'b0001);
    chk("hold_recv_masked", recv_ready, 0);
    send_ready[0] = 0;
    tick();
    chk("hold_recv_next", recv_ready, 4'b1000);
    chk("hold_data1", recv_data[3], h1);
    recv_request[3] = 0;
    recv_request[2] = 1; recv_core_idx[2] = 0;
    tick();
    chk("hold_recv2", recv_ready, 4'b0100);
    chk("hold_data2", recv_data[2], h2);
    recv_request[2] = 0;
    tick();
    chk("hold_idle", idle, 1);

    // ---- same-edge drain and refill on mb[0][1] ----
    pd = rndp(); pc = rndp();
    send_ready[0] = 1; send_core_idx[0] = 1; send_data[0] = pd;
    tick();
    chk("sre_fill", send_ok, 4'b0001);
    send_data[0] = pc;
    recv_request[1] = 1; recv_core_idx[1] = 0;
    tick();
    chk("sre_drain", recv_ready, 4'b0010);
    chk("sre_old_data", recv_data[1], pd);
    chk("sre_write_blocked", send_ok, 0);
    tick();
    chk("sre_refill", send_ok, 4'b0001);
    chk("sre_no_dup_recv", recv_ready, 0);
    tick();
    chk("sre_recv_c", recv_ready, 4'b0010);
    chk("sre_data_c", recv_data[1], pc);
    chk("sre_no_dup_ack", send_ok, 0);
    send_ready[0] = 0; recv_request[1] = 0;
    tick();
    chk("sre_idle", idle, 1);

    // ---- reset discards an in-flight message ----
    send_ready[2] = 1; send_core_idx[2] = 0; send_data[2] = rndp();
    tick();
    chk("rmid_ack", send_ok, 4'b0100);
    send_ready[2] = 0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    recv_request[0] = 1; recv_core_idx[0] = 2;
    hits = 0;
    repeat (10) begin tick(); if (recv_ready[0]) hits++; end
    chk("rmid_no_recv", hits, 0);
    chk("rmid_idle", idle, 1);
    recv_request[0] = 0;
    tick();

    // ---- randomized traffic against per-pair FIFO model ----
    for (int p = 0; p < N; p++) begin s_tmo[p] = 0; r_tmo[p] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int p = 0; p < N; p++) begin
        if (recv_ready[p]) begin
          src = int'(recv_core_idx[p]);
          k = src * N + p;
          chk("rand_recv_pending", 32'(q[k].size()), 1);
          if (q[k].size() != 0) chk("rand_recv_data", recv_data[p], q[k].pop_front());
        end
      end
      for (int p = 0; p < N; p++) begin
        if (send_ok[p]) begin
          k = p * N + int'(send_core_idx[p]);
          q[k].push_back(send_data[p]);
          chk("rand_depth", 32'(q[k].size()), 1);
        end
      end
      mid = 1'b1;
      for (int i = 0; i < N * N; i++) if (q[i].size() != 0) mid = 1'b0;
      if (send_ok != 0 || recv_ready != 0) mid = 1'b0;
      chk("rand_idle", idle, mid);
      for (int p = 0; p < N; p++) begin
        if (send_ready[p]) begin
          if (send_ok[p] || s_tmo[p] == 0) send_ready[p] = 0;
          else s_tmo[p]--;
        end
        if (!send_ready[p] && $urandom_range(0, 2) == 0) begin
          send_ready[p] = 1;
          send_core_idx[p] = A'($urandom_range(0, N - 1));
          send_data[p] = rndp();
          s_tmo[p] = $urandom_range(2, 10);
        end
        if (recv_request[p]) begin
          if (recv_ready[p] || r_tmo[p] == 0) recv_request[p] = 0;
          else r_tmo[p]--;
        end
        if (!recv_request[p] && $urandom_range(0, 2) == 0) begin
          recv_request[p] = 1;
          recv_core_idx[p] = A'($urandom_range(0, N - 1));
          r_tmo[p] = $urandom_range(2, 10);
        end
      end
    end

    // Account for any pulse from the last random edge, then drain every pair.
    send_ready = '0; recv_request = '0;
    tick();
    for (int p = 0; p < N; p++) begin
      if (recv_ready[p]) begin
        k = int'(recv_core_idx[p]) * N + p;
        chk("tail_recv_pending", 32'(q[k].size()), 1);
        if (q[k].size() != 0) chk("tail_recv_data", recv_data[p], q[k].pop_front());
      end
      if (send_ok[p]) q[p * N + int'(send_core_idx[p])].push_back(send_data[p]);
    end
    tick();
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        k = s * N + d;
        recv_request[d] = 1; recv_core_idx[d] = A'(s);
        tick();
        chk("drain_ready", recv_ready[d], (q[k].size() != 0));
        if (recv_ready[d] && q[k].size() != 0) chk("drain_data", recv_data[d], q[k].pop_front());
        recv_request[d] = 0;
        tick();
      end
    end
    chk("final_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
